// File: rtl/pulse_frame_capture.sv
// Deserialises WIDTH-bit frames (MSB first) from a serial pulse stream and reports
// the captured word, ones count, rising-edge count and a pattern compare.
module pulse_frame_capture #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       delay,
    input  logic             continuous,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] pattern_in,
    output logic [WIDTH-1:0] word_out,
    output logic [CNT_W-1:0] ones_count,
    output logic [CNT_W-1:0] pulse_count,
    output logic             match,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       align_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] ones_acc_q;
    logic [CNT_W-1:0] edge_acc_q;
    logic             prev_q;
    logic [WIDTH-1:0] word_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] pulse_q;
    logic             match_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] ones_acc_d;
    logic [CNT_W-1:0] edge_acc_d;
    logic             last_c;

    // Values after absorbing the current sample; the last-bit edge publishes these directly.
    always_comb begin
        shreg_d    = {shreg_q[WIDTH-2:0], serial_in};
        ones_acc_d = ones_acc_q + CNT_W'(serial_in);
        edge_acc_d = edge_acc_q + CNT_W'(serial_in & ~prev_q);
        last_c     = (bit_cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            align_q    <= 4'd0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ones_acc_q <= '0;
            edge_acc_q <= '0;
            prev_q     <= 1'b0;
            word_q     <= '0;
            ones_q     <= '0;
            pulse_q    <= '0;
            match_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        shreg_q    <= '0;
                        ones_acc_q <= '0;
                        edge_acc_q <= '0;
                        bit_cnt_q  <= '0;
                        prev_q     <= 1'b0;
                        if (delay == 4'd0) begin
                            state_q <= CAPTURE;
                        end else begin
                            state_q <= ALIGN;
                            align_q <= delay - 4'd1;
                        end
                    end
                end
                // Skip generator latency; serial_in is ignored here.
                ALIGN: begin
                    if (align_q == 4'd0) begin
                        state_q <= CAPTURE;
                    end else begin
                        align_q <= align_q - 4'd1;
                    end
                end
                CAPTURE: begin
                    if (last_c) begin
                        word_q     <= shreg_d;
                        ones_q     <= ones_acc_d;
                        pulse_q    <= edge_acc_d;
                        match_q    <= (shreg_d == pattern_in);
                        done_q     <= 1'b1;
                        shreg_q    <= '0;
                        ones_acc_q <= '0;
                        edge_acc_q <= '0;
                        bit_cnt_q  <= '0;
                        prev_q     <= 1'b0;
                        if (!continuous) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        shreg_q    <= shreg_d;
                        ones_acc_q <= ones_acc_d;
                        edge_acc_q <= edge_acc_d;
                        prev_q     <= serial_in;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign word_out    = word_q;
    assign ones_count  = ones_q;
    assign pulse_count = pulse_q;
    assign match       = match_q;
    assign done        = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_frame_capture.sv
// Scoreboard bench for pulse_frame_capture: the driver pushes hand-computed frame
// results, a negedge monitor pops one per done pulse and compares.
module tb_pulse_frame_capture;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       delay;
    logic             continuous;
    logic             serial_in;
    logic [WIDTH-1:0] pattern_in;
    logic [WIDTH-1:0] word_out;
    logic [CNT_W-1:0] ones_count;
    logic [CNT_W-1:0] pulse_count;
    logic             match;
    logic             done;
    logic             busy;

    pulse_frame_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start(start), .delay(delay),
        .continuous(continuous), .serial_in(serial_in), .pattern_in(pattern_in),
        .word_out(word_out), .ones_count(ones_count), .pulse_count(pulse_count),
        .match(match), .done(done), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               ones;
        int               pulses;
        logic             mat;
        logic             bsy;
        int               at_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must correspond to exactly one pending expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("word_out", int'(word_out), int'(e.word));
                check("ones_count", int'(ones_count), e.ones);
                check("pulse_count", int'(pulse_count), e.pulses);
                check("match", int'(match), int'(e.mat));
                check("busy_at_done", int'(busy), int'(e.bsy));
                check("done_cycle", cyc, e.at_cyc);
            end
        end
    end

    task automatic push(input logic [WIDTH-1:0] w, input int o, input int p,
                        input logic m, input logic b, input int at);
        exp_t x;
        x.word = w; x.ones = o; x.pulses = p; x.mat = m; x.bsy = b; x.at_cyc = at;
        sb.push_back(x);
    endtask

    task automatic drive_bits(input logic [WIDTH-1:0] w, input bit repulse, input bit cont_last);
        for (int i = 0; i < int'(WIDTH); i++) begin
            serial_in  = w[WIDTH-1-i];
            start      = repulse && (i == 5);
            continuous = cont_last && (i == int'(WIDTH) - 1);
            @(negedge clock);
        end
        start      = 1'b0;
        continuous = 1'b0;
    endtask

    task automatic run_frame(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] pat,
                             input int d, input logic junk, input bit repulse,
                             input bit cont_last, input int o, input int p, input logic m);
        pattern_in = pat;
        delay      = 4'(d);
        start      = 1'b1;
        push(w, o, p, m, cont_last, cyc + 1 + int'(WIDTH) + d);
        @(negedge clock);
        start = 1'b0;
        delay = 4'd0;
        for (int i = 0; i < d; i++) begin
            serial_in = junk;
            @(negedge clock);
        end
        drive_bits(w, repulse, cont_last);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_word"}, int'(word_out), 0);
        check({tag, "_ones"}, int'(ones_count), 0);
        check({tag, "_pulses"}, int'(pulse_count), 0);
        check({tag, "_match"}, int'(match), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; delay = 4'd0; continuous = 1'b0;
        serial_in = 1'b0; pattern_in = '0;
        repeat (3) @(negedge clock);
        check_cleared("reset");
        reset = 1'b0;
        @(negedge clock);

        run_frame(16'hA5C3, 16'hA5C3, 0, 1'b0, 1'b0, 1'b0, 8, 5, 1'b1);
        run_frame(16'hF00F, 16'hF00F, 1, 1'b0, 1'b0, 1'b0, 8, 2, 1'b1);
        run_frame(16'hFFFF, 16'h0000, 3, 1'b1, 1'b0, 1'b0, 16, 1, 1'b0);
        @(negedge clock);

        // Back-to-back frames: second done exactly WIDTH cycles after the first.
        run_frame(16'h0001, 16'h0001, 0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b1);
        pattern_in = 16'h8000;
        push(16'h8000, 1, 1, 1'b1, 1'b0, cyc + int'(WIDTH));
        drive_bits(16'h8000, 1'b0, 1'b0);
        @(negedge clock);

        // Start during capture is ignored; start on the done cycle is accepted.
        run_frame(16'hA5C3, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 8, 5, 1'b0);
        run_frame(16'h3C5A, 16'h3C5A, 0, 1'b0, 1'b0, 1'b0, 8, 4, 1'b1);
        @(negedge clock);

        // Abort mid-frame: previous result holds while busy, then reset clears everything.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            serial_in = 1'b1;
            @(negedge clock);
        end
        check("busy_mid_frame", int'(busy), 1);
        check("word_holds_mid_frame", int'(word_out), 16'h3C5A);
        reset = 1'b1;
        #1;
        check_cleared("abort");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_frame(16'h0F0F, 16'h0F0F, 0, 1'b0, 1'b0, 1'b0, 8, 2, 1'b1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        check("pending_expectations", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
